// File: rtl/toyup_io_peer.sv
// toyup_io_peer -- host-side peer for a toy microprocessor's 8-bit I/O ports.
//
// Purpose:
//   * OPORT capture: up_oport is sampled every cycle, and each change is
//     pushed into a small show-ahead FIFO that the host drains.
//     - When a change arrives with the FIFO full and no pop on the same edge,
//       the value is dropped and the sticky ovf flag is set.
//   * IPORT drive: a value from the host is registered onto up_iport.
//     - After each accept, the block holds that value for HOLD_CYCLES cycles
//       before it accepts the next one.
//
// Optional feature (macro TOYUP_IO_FIRST_SAMPLE_EN):
//   * Defined: the first edge after reset pushes up_oport unconditionally, so a
//     reset-level value (even 0x00) reaches the host.
//   * Undefined (default): only real changes are pushed.
//
// Parameters:
//   DEPTH        capture FIFO depth (power of two, 2..16)
//   HOLD_CYCLES  cycles up_iport is held after an accept (1..255)
//
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   up_oport         sampled copy of the microprocessor OPORT
//   up_iport         registered value driving the microprocessor IPORT
//   host_in_*        valid/ready input channel for the next IPORT value
//   host_out_*       valid/ready show-ahead output of captured OPORT values
//   ovf, ovf_clr     sticky drop flag and its clear
module toyup_io_peer #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] up_oport,
  output logic [7:0] up_iport,
  input  logic [7:0] host_in_data,
  input  logic       host_in_valid,
  output logic       host_in_ready,
  output logic [7:0] host_out_data,
  output logic       host_out_valid,
  input  logic       host_out_ready,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [7:0]    HOLD_LOAD  = 8'(HOLD_CYCLES);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]    oport_q,    oport_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          ovf_q,      ovf_d;
  logic [7:0]    iport_q,    iport_d;
  logic [7:0]    cnt_q,      cnt_d;
  state_t        state_q,    state_d;
`ifdef TOYUP_IO_FIRST_SAMPLE_EN
  logic          primed_q;
`endif

  logic          change;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic [AW-1:0] next_rd;

  // ---------------------------------------------------------------------------
  // OPORT change detection and capture FIFO
  // ---------------------------------------------------------------------------
  always_comb begin
`ifdef TOYUP_IO_FIRST_SAMPLE_EN
    change = (up_oport != oport_q) || !primed_q;
`else
    change = (up_oport != oport_q);
`endif
    full    = (count_q == FULL_COUNT);
    pop     = (count_q != '0) && host_out_ready;
    // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
    push_ok = change && (!full || pop);
    drop    = change && full && !pop;
    next_rd = rd_ptr_q + AW'(1);

    oport_d  = up_oport;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? next_rd           : rd_ptr_q;

    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CW'(1);
    end

    // The head is kept in its own register so it can hold its last value
    // once the FIFO drains. It must track whatever becomes the new oldest entry.
    out_data_d = out_data_q;
    if (count_q == '0) begin
      if (push_ok) begin
        out_data_d = up_oport;
      end
    end else if (pop) begin
      if (count_q >= CW'(2)) begin
        out_data_d = mem_q[next_rd];
      end else if (push_ok) begin
        // The last entry leaves and the value pushed on this edge becomes the head.
        out_data_d = up_oport;
      end
    end

    // On the same edge, a new drop takes priority over a clear.
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Storage array without reset. Contents are only meaningful between the
  // pointers, and the pointers are reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_ptr_q] <= up_oport;
    end
  end

  // ---------------------------------------------------------------------------
  // IPORT hold FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iport_d = iport_q;
    unique case (state_q)
      IDLE: begin
        if (host_in_valid) begin
          iport_d = host_in_data;
          cnt_d   = HOLD_LOAD;
          state_d = HOLD;
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 8'd1;
        // The counter reaches zero on this edge, which ends the hold.
        if (cnt_q <= 8'd1) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      oport_q    <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_data_q <= 8'h00;
      ovf_q      <= 1'b0;
      iport_q    <= 8'h00;
      cnt_q      <= 8'h00;
      state_q    <= IDLE;
    end else begin
      oport_q    <= oport_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
      iport_q    <= iport_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
    end
  end

`ifdef TOYUP_IO_FIRST_SAMPLE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      primed_q <= 1'b0;
    end else begin
      primed_q <= 1'b1;
    end
  end
`endif

  assign up_iport       = iport_q;
  assign host_in_ready  = (state_q == IDLE);
  assign host_out_data  = out_data_q;
  assign host_out_valid = (count_q != '0);
  assign ovf            = ovf_q;

endmodule

// File: tb/tb_toyup_io_peer.sv
// tb_toyup_io_peer -- directed self-checking bench for toyup_io_peer.
//
// Reference model:
//   * OPORT capture is modelled as a queue of values.
//   * IPORT hold is modelled as an edge-number timestamp giving the first
//     edge after which the next value may be accepted.
//
// Checking:
//   * After every edge, all outputs are compared against the model.
//   * Literal expectations at key points pin the model itself.
//
// Builds with or without TOYUP_IO_FIRST_SAMPLE_EN.
module tb_toyup_io_peer;

  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic       clk;
  logic       rst;
  logic [7:0] up_oport;
  logic [7:0] up_iport;
  logic [7:0] host_in_data;
  logic       host_in_valid;
  logic       host_in_ready;
  logic [7:0] host_out_data;
  logic       host_out_valid;
  logic       host_out_ready;
  logic       ovf;
  logic       ovf_clr;

  toyup_io_peer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk            (clk),
    .rst            (rst),
    .up_oport       (up_oport),
    .up_iport       (up_iport),
    .host_in_data   (host_in_data),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .host_out_data  (host_out_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .ovf            (ovf),
    .ovf_clr        (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [7:0] mq[$];
  logic [7:0] m_prev   = 8'h00;
  logic [7:0] m_shown  = 8'h00;
  logic [7:0] m_iport  = 8'h00;
  bit         m_ovf    = 1'b0;
  bit         m_ready  = 1'b1;
  bit         m_primed = 1'b0;
  int         cyc       = 0;
  int         next_free = 0;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %02h, expected %02h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Apply the rules to the inputs as they stood at the edge just taken.
  task automatic model_update();
    int  sz;
    bit  pop;
    bit  chg;
    bit  drop;
    cyc++;
    if (rst) begin
      mq.delete();
      m_prev    = 8'h00;
      m_shown   = 8'h00;
      m_iport   = 8'h00;
      m_ovf     = 1'b0;
      m_primed  = 1'b0;
      next_free = cyc;
      m_ready   = 1'b1;
    end else begin
      sz   = mq.size();
      pop  = (sz > 0) && host_out_ready;
      chg  = (up_oport != m_prev);
`ifdef TOYUP_IO_FIRST_SAMPLE_EN
      if (!m_primed) chg = 1'b1;
`endif
      drop = 1'b0;
      if (pop) void'(mq.pop_front());
      if (chg) begin
        if (sz < DEPTH || pop) mq.push_back(up_oport);
        else drop = 1'b1;
      end
      if (mq.size() > 0) m_shown = mq[0];
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_prev   = up_oport;
      m_primed = 1'b1;
      if (m_ready && host_in_valid) begin
        m_iport   = host_in_data;
        next_free = cyc + HOLD;
      end
      m_ready = (cyc >= next_free);
    end
  endtask

  // One clock: edge, model update, then compare all outputs 2 time units later.
  task automatic step();
    @(posedge clk);
    model_update();
    #2;
    chk1("out_valid", host_out_valid, mq.size() > 0);
    chk8("out_data",  host_out_data,  m_shown);
    chk1("ovf",       ovf,            m_ovf);
    chk8("iport",     up_iport,       m_iport);
    chk1("in_ready",  host_in_ready,  m_ready);
    $display("edge %0d: oport=%02h rdy=%b -> out v=%b d=%02h ovf=%b iport=%02h in_rdy=%b",
             cyc, up_oport, host_out_ready, host_out_valid, host_out_data, ovf,
             up_iport, host_in_ready);
  endtask

  logic [7:0] vec_oport [12] = '{8'h40, 8'h41, 8'h41, 8'h42, 8'h43, 8'h44,
                                 8'h45, 8'h45, 8'h46, 8'h00, 8'hFF, 8'hFF};
  bit         vec_rdy   [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  bit         vec_clr   [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int lows;
    rst = 1'b1; up_oport = 8'h00; host_in_data = 8'h00; host_in_valid = 1'b0;
    host_out_ready = 1'b0; ovf_clr = 1'b0;

    // Reset state
    step(); step();
    chk1("lit_rst_valid", host_out_valid, 1'b0);
    chk8("lit_rst_data",  host_out_data,  8'h00);
    chk8("lit_rst_iport", up_iport,       8'h00);
    chk1("lit_rst_ready", host_in_ready,  1'b1);
    chk1("lit_rst_ovf",   ovf,            1'b0);

    // First post-reset edge with a reset-level OPORT value
    rst = 1'b0;
    step();
`ifdef TOYUP_IO_FIRST_SAMPLE_EN
    chk1("lit_first_valid", host_out_valid, 1'b1);
    chk8("lit_first_data",  host_out_data,  8'h00);
`else
    chk1("lit_first_valid", host_out_valid, 1'b0);
`endif
    host_out_ready = 1'b1; step(); host_out_ready = 1'b0;
    chk1("lit_drained", host_out_valid, 1'b0);

    // Single change 0x00 -> 0x5A, then held
    up_oport = 8'h5A; step();
    chk1("lit_5a_valid", host_out_valid, 1'b1);
    chk8("lit_5a_data",  host_out_data,  8'h5A);
    step();
    chk1("lit_5a_single", host_out_valid, 1'b1);
    host_out_ready = 1'b1; step(); host_out_ready = 1'b0;
    chk1("lit_5a_empty", host_out_valid, 1'b0);
    chk8("lit_5a_hold",  host_out_data,  8'h5A);

    // Overflow: 01..05 with no pops
    for (int v = 1; v <= 5; v++) begin
      up_oport = 8'(v); step();
    end
    chk1("lit_ovf_set",  ovf,           1'b1);
    chk8("lit_ovf_head", host_out_data, 8'h01);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk1("lit_ovf_clr", ovf, 1'b0);

    // Full FIFO with a simultaneous push and pop
    up_oport = 8'h77; host_out_ready = 1'b1; step();
    chk8("lit_fullpp_head", host_out_data, 8'h02);
    chk1("lit_fullpp_ovf",  ovf,           1'b0);
    step(); step(); step();
    chk8("lit_fullpp_tail", host_out_data, 8'h77);
    step();
    chk1("lit_fullpp_empty", host_out_valid, 1'b0);
    host_out_ready = 1'b0;

    // When an overflow and ovf_clr fall on the same edge, the overflow wins
    for (int v = 16; v <= 19; v++) begin
      up_oport = 8'(v); step();
    end
    up_oport = 8'h14; ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk1("lit_set_wins", ovf, 1'b1);
    host_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    host_out_ready = 1'b0;

    // Simultaneous push and pop on an empty FIFO
    up_oport = 8'h20; host_out_ready = 1'b1; step();
    chk1("lit_emptypp_valid", host_out_valid, 1'b1);
    chk8("lit_emptypp_data",  host_out_data,  8'h20);
    step(); host_out_ready = 1'b0;

    // IPORT hold
    host_in_data = 8'hA5; host_in_valid = 1'b1; step();
    chk8("lit_iport_a5", up_iport,      8'hA5);
    chk1("lit_hold_rdy", host_in_ready, 1'b0);
    host_in_data = 8'h3C;
    lows = 1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (host_in_ready) break;
      lows++;
    end
    chki("lit_hold_len", lows, HOLD);
    chk8("lit_iport_stable", up_iport, 8'hA5);
    step();
    chk8("lit_iport_3c", up_iport, 8'h3C);
    host_in_valid = 1'b0;

    // Reset during HOLD with two FIFO entries
    up_oport = 8'h31; step();
    up_oport = 8'h32; step();
    chk1("lit_pre_rst_valid", host_out_valid, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    chk8("lit_mid_rst_iport", up_iport,       8'h00);
    chk1("lit_mid_rst_ready", host_in_ready,  1'b1);
    chk1("lit_mid_rst_valid", host_out_valid, 1'b0);
    chk8("lit_mid_rst_data",  host_out_data,  8'h00);

    // Mixed vectors exercising pointer wrap and head tracking
    for (int i = 0; i < 12; i++) begin
      up_oport = vec_oport[i]; host_out_ready = vec_rdy[i]; ovf_clr = vec_clr[i];
      step();
    end
    host_out_ready = 1'b1; ovf_clr = 1'b0;
    for (int i = 0; i < 6; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
